accum_sequencer: RTL and testbench

ACCUM_SEQUENCER -- requirements
Module: accum_sequencer

---
 rtl/accum_sequencer_if.sv | 27 ++
 rtl/accum_sequencer.sv | 121 ++++++++++++
 tb/tb_accum_sequencer.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/accum_sequencer_if.sv
// Control/status bundle between an accumulate-sequencer client and the sequencer.
// master drives the start/cancel/mode request and adder carry; slave returns datapath controls and status.
interface accum_sequencer_if #(
    parameter int CW = 8
);
    logic          Run;
    logic          Abort;
    logic          Mode;
    logic [CW-1:0] Count;
    logic          Cout;
    logic [1:0]    Sel;
    logic          Load;
    logic          Busy;
    logic          Done;
    logic [CW-1:0] Remaining;
    logic          Ovf;

    modport master (
        output Run, Abort, Mode, Count, Cout,
        input  Sel, Load, Busy, Done, Remaining, Ovf
    );

    modport slave (
        input  Run, Abort, Mode, Count, Cout,
        output Sel, Load, Busy, Done, Remaining, Ovf
    );
endinterface

// File: rtl/accum_sequencer.sv
// Sequences accumulator mux/load for single-add or repeated-add multiply, tracking sticky carry.
// Latency: mode 1 = Count+1 load cycles then Done; mode 0 = one load then Done.
// No backpressure: Run is edge-detected, Abort cancels at once, HOLD waits for Run to drop.
module accum_sequencer #(
    parameter int CW = 8
) (
    input  logic               Clk,
    input  logic               Reset_Clear,
    accum_sequencer_if.slave   bus
);
    localparam logic [1:0] SEL_HOLD = 2'b00;
    localparam logic [1:0] SEL_SUM  = 2'b10;
    localparam logic [1:0] SEL_ZERO = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ADD,
        S_DONE,
        S_HOLD
    } state_t;

    state_t        state, state_nxt;
    logic          run_q;
    logic [CW-1:0] remaining, remaining_nxt;
    logic          ovf, ovf_nxt;
    logic [1:0]    sel;
    logic          load;
    logic          busy;
    logic          done;
    logic          start;

    // run_q resets high so a Run held across reset release is not seen as an edge
    assign start = bus.Run & ~run_q;

    always_ff @(posedge Clk or negedge Reset_Clear) begin
        if (!Reset_Clear) begin
            state     <= S_IDLE;
            run_q     <= 1'b1;
            remaining <= '0;
            ovf       <= 1'b0;
        end else begin
            state     <= state_nxt;
            run_q     <= bus.Run;
            remaining <= remaining_nxt;
            ovf       <= ovf_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        ovf_nxt       = ovf;
        sel           = SEL_HOLD;
        load          = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;

        case (state)
            S_IDLE: begin
                if (start && !bus.Abort) begin
                    if (bus.Mode) begin
                        state_nxt     = S_CLEAR;
                        remaining_nxt = bus.Count;
                    end else begin
                        state_nxt     = S_ADD;
                        remaining_nxt = CW'(1);
                        ovf_nxt       = 1'b0;
                    end
                end
            end

            S_CLEAR: begin
                busy = 1'b1;
                if (bus.Abort) begin
                    state_nxt = bus.Run ? S_HOLD : S_IDLE;
                end else begin
                    sel       = SEL_ZERO;
                    load      = 1'b1;
                    ovf_nxt   = 1'b0;
                    state_nxt = (remaining != '0) ? S_ADD : S_DONE;
                end
            end

            S_ADD: begin
                busy = 1'b1;
                if (bus.Abort) begin
                    state_nxt = bus.Run ? S_HOLD : S_IDLE;
                end else begin
                    sel     = SEL_SUM;
                    load    = 1'b1;
                    ovf_nxt = ovf | bus.Cout;
                    // saturate at zero so a stray extra cycle can never wrap the count
                    if (remaining != '0)
                        remaining_nxt = remaining - CW'(1);
                    if (remaining <= CW'(1))
                        state_nxt = S_DONE;
                end
            end

            S_DONE: begin
                done      = 1'b1;
                state_nxt = bus.Run ? S_HOLD : S_IDLE;
            end

            S_HOLD: begin
                if (!bus.Run)
                    state_nxt = S_IDLE;
            end

            default: state_nxt = S_IDLE;
        endcase
    end

    assign bus.Sel       = sel;
    assign bus.Load      = load;
    assign bus.Busy      = busy;
    assign bus.Done      = done;
    assign bus.Remaining = remaining;
    assign bus.Ovf       = ovf;
endmodule

// File: tb/tb_accum_sequencer.sv
// Scoreboard bench for accum_sequencer: directed scenarios queue expected Load/Done cycles,
// a negedge monitor pops and compares each one the DUT presents.
module tb_accum_sequencer;
    localparam int CW = 8;

    typedef struct packed {
        logic [1:0]    sel;
        logic          load;
        logic          busy;
        logic          done;
        logic [CW-1:0] rem;
        logic          ovf;
    } exp_t;

    logic Clk;
    logic Reset_Clear;
    int   n_cmp;
    int   n_bad;
    exp_t q[$];

    accum_sequencer_if #(.CW(CW)) bus();

    accum_sequencer #(.CW(CW)) dut (
        .Clk         (Clk),
        .Reset_Clear (Reset_Clear),
        .bus         (bus.slave)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic push(input logic [1:0] sel, input logic load, input logic busy,
                        input logic done, input logic [CW-1:0] rem, input logic ovf);
        exp_t e;
        e.sel = sel; e.load = load; e.busy = busy; e.done = done; e.rem = rem; e.ovf = ovf;
        q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 40 && q.size() != 0; i++)
            @(posedge Clk);
        #1;
        chk({name, " queue drained"}, q.size(), 0);
    endtask

    // Monitor: every Load or Done cycle must match the next queued expectation
    always @(negedge Clk) begin
        if (Reset_Clear && (bus.Load || bus.Done)) begin
            exp_t a, e;
            a.sel = bus.Sel; a.load = bus.Load; a.busy = bus.Busy;
            a.done = bus.Done; a.rem = bus.Remaining; a.ovf = bus.Ovf;
            n_cmp++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected event at %0t: sel=%b load=%b busy=%b done=%b rem=%0d ovf=%b",
                         $time, a.sel, a.load, a.busy, a.done, a.rem, a.ovf);
            end else begin
                e = q.pop_front();
                if (a !== e) begin
                    n_bad++;
                    $display("FAIL event at %0t: got sel=%b load=%b busy=%b done=%b rem=%0d ovf=%b expected sel=%b load=%b busy=%b done=%b rem=%0d ovf=%b",
                             $time, a.sel, a.load, a.busy, a.done, a.rem, a.ovf,
                             e.sel, e.load, e.busy, e.done, e.rem, e.ovf);
                end
            end
        end
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        Reset_Clear = 1'b0;
        bus.Run = 1'b0; bus.Abort = 1'b0; bus.Mode = 1'b0; bus.Count = '0; bus.Cout = 1'b0;

        #12;
        chk("reset Sel", bus.Sel, 0);
        chk("reset Load", bus.Load, 0);
        chk("reset Busy", bus.Busy, 0);
        chk("reset Done", bus.Done, 0);
        chk("reset Remaining", bus.Remaining, 0);
        chk("reset Ovf", bus.Ovf, 0);
        Reset_Clear = 1'b1;
        step(); step();

        // Mode 1, Count 3, one-cycle Run pulse
        bus.Mode = 1'b1; bus.Count = 8'd3;
        push(2'b11, 1, 1, 0, 8'd3, 0);
        push(2'b10, 1, 1, 0, 8'd3, 0);
        push(2'b10, 1, 1, 0, 8'd2, 0);
        push(2'b10, 1, 1, 0, 8'd1, 0);
        push(2'b00, 0, 0, 1, 8'd0, 0);
        bus.Run = 1'b1;
        step();
        bus.Run = 1'b0;
        drain("mul3");
        step();
        chk("mul3 idle Busy", bus.Busy, 0);

        // Mode 1, Count 4, carry only in 2nd ADD; Mode/Count changed after start
        bus.Mode = 1'b1; bus.Count = 8'd4;
        push(2'b11, 1, 1, 0, 8'd4, 0);
        push(2'b10, 1, 1, 0, 8'd4, 0);
        push(2'b10, 1, 1, 0, 8'd3, 0);
        push(2'b10, 1, 1, 0, 8'd2, 1);
        push(2'b10, 1, 1, 0, 8'd1, 1);
        push(2'b00, 0, 0, 1, 8'd0, 1);
        bus.Run = 1'b1;
        step();
        bus.Run = 1'b0; bus.Mode = 1'b0; bus.Count = 8'd0;
        step();
        step();
        bus.Cout = 1'b1;
        step();
        bus.Cout = 1'b0;
        drain("ovf4");
        step();
        chk("ovf4 sticky after Done", bus.Ovf, 1);

        // Mode 0 with Run held 10 cycles; Ovf cleared on entry, carry set during ADD
        bus.Mode = 1'b0; bus.Count = 8'd7; bus.Cout = 1'b1;
        push(2'b10, 1, 1, 0, 8'd1, 0);
        push(2'b00, 0, 0, 1, 8'd0, 1);
        bus.Run = 1'b1;
        repeat (10) step();
        chk("mode0 hold Busy", bus.Busy, 0);
        chk("mode0 queue empty in hold", q.size(), 0);
        bus.Run = 1'b0; bus.Cout = 1'b0;
        step(); step();

        // Mode 1, Count 0: CLEAR then DONE, Ovf cleared
        bus.Mode = 1'b1; bus.Count = 8'd0;
        push(2'b11, 1, 1, 0, 8'd0, 1);
        push(2'b00, 0, 0, 1, 8'd0, 0);
        bus.Run = 1'b1;
        step();
        bus.Run = 1'b0;
        drain("count0");
        step();

        // Mode 1, Count 5, Abort in 3rd ADD with Run held
        bus.Mode = 1'b1; bus.Count = 8'd5;
        push(2'b11, 1, 1, 0, 8'd5, 0);
        push(2'b10, 1, 1, 0, 8'd5, 0);
        push(2'b10, 1, 1, 0, 8'd4, 0);
        bus.Run = 1'b1;
        step(); step(); step(); step();
        bus.Abort = 1'b1;
        @(negedge Clk);
        chk("abort Load", bus.Load, 0);
        chk("abort Done", bus.Done, 0);
        step();
        bus.Abort = 1'b0;
        @(negedge Clk);
        chk("abort Remaining held", bus.Remaining, 3);
        chk("abort Busy after", bus.Busy, 0);
        chk("abort Ovf held", bus.Ovf, 0);
        bus.Run = 1'b0;
        step(); step();
        chk("abort queue empty", q.size(), 0);

        // Abort coincident with start suppresses it
        bus.Mode = 1'b0;
        bus.Run = 1'b1; bus.Abort = 1'b1;
        step();
        bus.Abort = 1'b0;
        step(); step(); step();
        chk("abort-start Busy", bus.Busy, 0);
        bus.Run = 1'b0;
        step();

        // Reset mid-operation, Run held across reset release
        bus.Mode = 1'b1; bus.Count = 8'd5;
        push(2'b11, 1, 1, 0, 8'd5, 0);
        push(2'b10, 1, 1, 0, 8'd5, 0);
        bus.Run = 1'b1;
        step(); step();
        @(negedge Clk);
        #1 Reset_Clear = 1'b0;
        #1;
        chk("midreset Busy", bus.Busy, 0);
        chk("midreset Load", bus.Load, 0);
        chk("midreset Done", bus.Done, 0);
        chk("midreset Remaining", bus.Remaining, 0);
        repeat (2) @(negedge Clk);
        Reset_Clear = 1'b1;
        step(); step(); step();
        chk("run-high release Busy", bus.Busy, 0);
        chk("midreset queue empty", q.size(), 0);
        bus.Run = 1'b0;
        step();
        bus.Mode = 1'b0;
        push(2'b10, 1, 1, 0, 8'd1, 0);
        push(2'b00, 0, 0, 1, 8'd0, 0);
        bus.Run = 1'b1;
        drain("restart");
        bus.Run = 1'b0;
        step(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
